inst_fetch_ctrl: RTL

- Consumer end of the PC interface: takes the current fetch address `pc` from the PC register and drives its `pc_en`.
- Issues one instruction-memory read per PC value over a valid/ready request channel and accepts the response.
- Presents {pc, inst} to decode with a valid/ready handshake, and handles flush/redirect and misaligned-fetch (ADEF) detection.
- Sits between the PC register, instruction memory and the ID stage of the LoongArch-32 core.

---
 rtl/inst_fetch_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer between the PC register, instruction memory and ID.
// Keeps one memory read in flight and hands {pc, inst, adef} to decode.
module inst_fetch_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adef,
    input  logic        id_ready
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DROP} state_t;
    state_t state;
    logic misaligned, req_fire;
    assign misaligned     = pc[1:0] != 2'b00;
    assign imem_req_valid = state == REQ && !misaligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // rst gates pc_en so the PC cannot move while the fetch side is held in reset
    assign pc_en          = rst && (flush || (state == OUT && id_ready));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
            if_adef  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (flush) begin
                        state <= req_fire ? DROP : REQ;
                    end else if (misaligned) begin
                        state    <= OUT;
                        if_valid <= 1'b1;
                        if_adef  <= 1'b1;
                        if_inst  <= NOP_INST;
                        if_pc    <= pc;
                    end else if (req_fire) begin
                        state   <= WAIT;
                        if_adef <= 1'b0;
                        if_pc   <= pc;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state    <= flush ? REQ : OUT;
                        if_valid <= !flush;
                        if_inst  <= flush ? if_inst : imem_resp_data;
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                OUT: begin
                    if (flush || id_ready) begin
                        state    <= REQ;
                        if_valid <= 1'b0;
                    end
                end
                // the stale response is the only outstanding one, so its arrival frees the channel
                DROP: state <= imem_resp_valid ? REQ : DROP;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
